// File: rtl/ff_bank_univ.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ff_bank_univ                                                 |
// | Description : Bank of WIDTH universal flip-flops (D/T/SR/JK) on a T-FF    |
// |               core, with mode register, sticky SR-conflict flag and a      |
// |               saturating toggle-activity counter.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ff_bank_univ #(
    parameter int unsigned         WIDTH   = 8,
    parameter logic [WIDTH-1:0]    RST_VAL = '0,
    parameter int unsigned         SR_BOTH = 0,
    parameter int unsigned         CNT_W   = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              en,
    input  logic              mode_ld,
    input  logic [1:0]        mode_in,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              err_clr,
    input  logic              cnt_clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic [1:0]        mode,
    output logic              sr_err,
    output logic [CNT_W-1:0]  tog_cnt
);

    localparam logic [1:0] c_MODE_D  = 2'd0;
    localparam logic [1:0] c_MODE_T  = 2'd1;
    localparam logic [1:0] c_MODE_SR = 2'd2;
    localparam logic [1:0] c_MODE_JK = 2'd3;

    logic [WIDTH-1:0] r_q;
    logic [1:0]       r_mode;
    logic             r_sr_err;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_both;
    logic [WIDTH-1:0] w_nx;
    logic [WIDTH-1:0] w_t;
    logic             w_any_t;
    logic             w_sr_set;
    logic             w_cnt_sat;

    // Next-state contribution of bits where S=R=1, fixed at elaboration.
    generate
        if (SR_BOTH == 1) begin : g_both_set
            assign w_both = '1;
        end else if (SR_BOTH == 2) begin : g_both_reset
            assign w_both = '0;
        end else if (SR_BOTH == 3) begin : g_both_toggle
            assign w_both = ~r_q;
        end else begin : g_both_hold
            assign w_both = r_q;
        end
    endgenerate

    always_comb begin
        w_nx = r_q;
        case (r_mode)
            c_MODE_D:  w_nx = a;
            c_MODE_T:  w_nx = r_q ^ a;
            c_MODE_SR: w_nx = (a & ~b) | (~a & ~b & r_q) | (a & b & w_both);
            c_MODE_JK: w_nx = (a & ~r_q) | (~b & r_q);
            default:   w_nx = r_q;
        endcase
    end

    // Every mode collapses to a per-bit toggle enable for the T-FF core.
    assign w_t       = w_nx ^ r_q;
    assign w_any_t   = |w_t;
    assign w_sr_set  = en && (r_mode == c_MODE_SR) && (|(a & b));
    assign w_cnt_sat = &r_cnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_q      <= RST_VAL;
            r_mode   <= c_MODE_D;
            r_sr_err <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (mode_ld) begin
                r_mode <= mode_in;
            end
            if (en) begin
                r_q <= r_q ^ w_t;
            end
            // Set has priority so a conflict is never lost to a coincident clear.
            if (w_sr_set) begin
                r_sr_err <= 1'b1;
            end else if (err_clr) begin
                r_sr_err <= 1'b0;
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (en && w_any_t && !w_cnt_sat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign q       = r_q;
    assign qn      = ~r_q;
    assign mode    = r_mode;
    assign sr_err  = r_sr_err;
    assign tog_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ff_bank_univ.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ff_bank_univ                                              |
// | Description : Directed self-checking bench for ff_bank_univ, four          |
// |               parameter variants sharing one stimulus stream.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ff_bank_univ;

    logic        clk = 1'b0;
    logic        r_res = 1'b0;
    logic        r_en = 1'b0;
    logic        r_mode_ld = 1'b0;
    logic [1:0]  r_mode_in = 2'd0;
    logic [7:0]  r_a = 8'h00;
    logic [7:0]  r_b = 8'h00;
    logic        r_err_clr = 1'b0;
    logic        r_cnt_clr = 1'b0;

    logic [7:0]  w_q_m, w_qn_m;
    logic [1:0]  w_mode_m;
    logic        w_err_m;
    logic [15:0] w_cnt_m;

    logic [7:0]  w_q_1, w_qn_1;
    logic [1:0]  w_mode_1;
    logic        w_err_1;
    logic [1:0]  w_cnt_1;

    logic [7:0]  w_q_2, w_qn_2;
    logic [1:0]  w_mode_2;
    logic        w_err_2;
    logic [15:0] w_cnt_2;

    logic [7:0]  w_q_3, w_qn_3;
    logic [1:0]  w_mode_3;
    logic        w_err_3;
    logic [15:0] w_cnt_3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ff_bank_univ #(.WIDTH(8), .RST_VAL(8'hA5), .SR_BOTH(0), .CNT_W(16)) u_main (
        .clk(clk), .res(r_res), .en(r_en), .mode_ld(r_mode_ld), .mode_in(r_mode_in),
        .a(r_a), .b(r_b), .err_clr(r_err_clr), .cnt_clr(r_cnt_clr),
        .q(w_q_m), .qn(w_qn_m), .mode(w_mode_m), .sr_err(w_err_m), .tog_cnt(w_cnt_m));

    ff_bank_univ #(.WIDTH(8), .RST_VAL(8'h00), .SR_BOTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .res(r_res), .en(r_en), .mode_ld(r_mode_ld), .mode_in(r_mode_in),
        .a(r_a), .b(r_b), .err_clr(r_err_clr), .cnt_clr(r_cnt_clr),
        .q(w_q_1), .qn(w_qn_1), .mode(w_mode_1), .sr_err(w_err_1), .tog_cnt(w_cnt_1));

    ff_bank_univ #(.WIDTH(8), .RST_VAL(8'h00), .SR_BOTH(2), .CNT_W(16)) u_s2 (
        .clk(clk), .res(r_res), .en(r_en), .mode_ld(r_mode_ld), .mode_in(r_mode_in),
        .a(r_a), .b(r_b), .err_clr(r_err_clr), .cnt_clr(r_cnt_clr),
        .q(w_q_2), .qn(w_qn_2), .mode(w_mode_2), .sr_err(w_err_2), .tog_cnt(w_cnt_2));

    ff_bank_univ #(.WIDTH(8), .RST_VAL(8'h00), .SR_BOTH(3), .CNT_W(16)) u_s3 (
        .clk(clk), .res(r_res), .en(r_en), .mode_ld(r_mode_ld), .mode_in(r_mode_in),
        .a(r_a), .b(r_b), .err_clr(r_err_clr), .cnt_clr(r_cnt_clr),
        .q(w_q_3), .qn(w_qn_3), .mode(w_mode_3), .sr_err(w_err_3), .tog_cnt(w_cnt_3));

    // Leaves the bench 1 time unit after the rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Off-edge reset pulse, entirely between two rising edges.
    task automatic pulse_reset();
        #2 r_res = 1'b1;
        #2 r_res = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        #3 r_res = 1'b1;
        #1;
        n_cmp++; if (w_q_m !== 8'hA5) begin n_err++; $display("FAIL rst_q actual=%h required=%h", w_q_m, 8'hA5); end
        n_cmp++; if (w_qn_m !== 8'h5A) begin n_err++; $display("FAIL rst_qn actual=%h required=%h", w_qn_m, 8'h5A); end
        n_cmp++; if (w_mode_m !== 2'd0) begin n_err++; $display("FAIL rst_mode actual=%0d required=0", w_mode_m); end
        n_cmp++; if (w_err_m !== 1'b0) begin n_err++; $display("FAIL rst_err actual=%b required=0", w_err_m); end
        n_cmp++; if (w_cnt_m !== 16'd0) begin n_err++; $display("FAIL rst_cnt actual=%0d required=0", w_cnt_m); end
        n_cmp++; if (w_q_1 !== 8'h00) begin n_err++; $display("FAIL rst_q_alt actual=%h required=00", w_q_1); end
        r_en = 1'b1; r_a = 8'hFF; r_mode_ld = 1'b1; r_mode_in = 2'd3;
        tick();
        n_cmp++; if (w_q_m !== 8'hA5) begin n_err++; $display("FAIL rst_hold_q actual=%h required=%h", w_q_m, 8'hA5); end
        n_cmp++; if (w_mode_m !== 2'd0) begin n_err++; $display("FAIL rst_hold_mode actual=%0d required=0", w_mode_m); end
        r_res = 1'b0; r_en = 1'b0; r_mode_ld = 1'b0; r_mode_in = 2'd0; r_a = 8'h00;
    endtask

    task automatic test_d_t();
        r_en = 1'b1; r_a = 8'h3C;
        tick();
        n_cmp++; if (w_q_m !== 8'h3C) begin n_err++; $display("FAIL d_q actual=%h required=3C", w_q_m); end
        n_cmp++; if (w_qn_m !== 8'hC3) begin n_err++; $display("FAIL d_qn actual=%h required=C3", w_qn_m); end
        r_mode_ld = 1'b1; r_mode_in = 2'd1; r_a = 8'hFF;
        tick();
        n_cmp++; if (w_q_m !== 8'hFF) begin n_err++; $display("FAIL ld_old_mode_q actual=%h required=FF", w_q_m); end
        n_cmp++; if (w_mode_m !== 2'd1) begin n_err++; $display("FAIL ld_mode actual=%0d required=1", w_mode_m); end
        r_mode_ld = 1'b0;
        tick();
        n_cmp++; if (w_q_m !== 8'h00) begin n_err++; $display("FAIL t_q actual=%h required=00", w_q_m); end
        r_a = 8'h81;
        tick();
        n_cmp++; if (w_q_m !== 8'h81) begin n_err++; $display("FAIL t_q2 actual=%h required=81", w_q_m); end
        n_cmp++; if (w_cnt_m !== 16'd4) begin n_err++; $display("FAIL dt_cnt actual=%0d required=4", w_cnt_m); end
        r_en = 1'b0; r_a = 8'h00;
    endtask

    task automatic test_sr();
        pulse_reset();
        r_en = 1'b1; r_a = 8'h00; r_b = 8'h00; r_mode_ld = 1'b1; r_mode_in = 2'd2;
        tick();
        r_mode_ld = 1'b0;
        n_cmp++; if (w_q_m !== 8'h00) begin n_err++; $display("FAIL sr_pre_q actual=%h required=00", w_q_m); end
        r_a = 8'h0F; r_b = 8'h00;
        tick();
        n_cmp++; if (w_q_m !== 8'h0F) begin n_err++; $display("FAIL sr_set_q actual=%h required=0F", w_q_m); end
        n_cmp++; if (w_err_m !== 1'b0) begin n_err++; $display("FAIL sr_noerr actual=%b required=0", w_err_m); end
        r_a = 8'h00; r_b = 8'h03;
        tick();
        n_cmp++; if (w_q_m !== 8'h0C) begin n_err++; $display("FAIL sr_rst_q actual=%h required=0C", w_q_m); end
        r_a = 8'h05; r_b = 8'h05;
        tick();
        n_cmp++; if (w_q_m !== 8'h0C) begin n_err++; $display("FAIL sr_both_hold actual=%h required=0C", w_q_m); end
        n_cmp++; if (w_err_m !== 1'b1) begin n_err++; $display("FAIL sr_err_set actual=%b required=1", w_err_m); end
        n_cmp++; if (w_q_1 !== 8'h0D) begin n_err++; $display("FAIL sr_both_set actual=%h required=0D", w_q_1); end
        n_cmp++; if (w_q_2 !== 8'h08) begin n_err++; $display("FAIL sr_both_reset actual=%h required=08", w_q_2); end
        n_cmp++; if (w_q_3 !== 8'h09) begin n_err++; $display("FAIL sr_both_toggle actual=%h required=09", w_q_3); end
        n_cmp++; if (w_err_2 !== 1'b1) begin n_err++; $display("FAIL sr_err_variant actual=%b required=1", w_err_2); end
        r_err_clr = 1'b1;
        tick();
        n_cmp++; if (w_err_m !== 1'b1) begin n_err++; $display("FAIL sr_set_wins actual=%b required=1", w_err_m); end
        n_cmp++; if (w_q_3 !== 8'h0C) begin n_err++; $display("FAIL sr_toggle_again actual=%h required=0C", w_q_3); end
        r_a = 8'h00; r_b = 8'h00;
        tick();
        n_cmp++; if (w_err_m !== 1'b0) begin n_err++; $display("FAIL sr_err_clr actual=%b required=0", w_err_m); end
        r_err_clr = 1'b0; r_en = 1'b0; r_a = 8'hFF; r_b = 8'hFF;
        tick();
        n_cmp++; if (w_err_m !== 1'b0) begin n_err++; $display("FAIL sr_err_gated actual=%b required=0", w_err_m); end
        n_cmp++; if (w_q_m !== 8'h0C) begin n_err++; $display("FAIL sr_en0_hold actual=%h required=0C", w_q_m); end
        n_cmp++; if (w_cnt_m !== 16'd3) begin n_err++; $display("FAIL sr_cnt actual=%0d required=3", w_cnt_m); end
        r_a = 8'h00; r_b = 8'h00;
    endtask

    task automatic test_jk();
        pulse_reset();
        r_en = 1'b1; r_a = 8'hF0; r_mode_ld = 1'b1; r_mode_in = 2'd3;
        tick();
        r_mode_ld = 1'b0;
        n_cmp++; if (w_q_m !== 8'hF0) begin n_err++; $display("FAIL jk_pre_q actual=%h required=F0", w_q_m); end
        r_a = 8'hFF; r_b = 8'hFF;
        tick();
        n_cmp++; if (w_q_m !== 8'h0F) begin n_err++; $display("FAIL jk_toggle actual=%h required=0F", w_q_m); end
        r_a = 8'h00; r_b = 8'h00;
        tick();
        n_cmp++; if (w_q_m !== 8'h0F) begin n_err++; $display("FAIL jk_hold actual=%h required=0F", w_q_m); end
        n_cmp++; if (w_cnt_m !== 16'd2) begin n_err++; $display("FAIL jk_cnt_hold actual=%0d required=2", w_cnt_m); end
        r_en = 1'b0; r_a = 8'hFF; r_b = 8'hFF;
        tick();
        n_cmp++; if (w_q_m !== 8'h0F) begin n_err++; $display("FAIL jk_en0 actual=%h required=0F", w_q_m); end
        r_en = 1'b1; r_a = 8'h33; r_b = 8'h55;
        tick();
        n_cmp++; if (w_q_m !== 8'h3A) begin n_err++; $display("FAIL jk_mixed actual=%h required=3A", w_q_m); end
        n_cmp++; if (w_cnt_m !== 16'd3) begin n_err++; $display("FAIL jk_cnt actual=%0d required=3", w_cnt_m); end
        r_en = 1'b0; r_a = 8'h00; r_b = 8'h00;
    endtask

    task automatic test_saturation();
        pulse_reset();
        r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_a = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        n_cmp++; if (w_cnt_1 !== 2'd3) begin n_err++; $display("FAIL sat_cnt4 actual=%0d required=3", w_cnt_1); end
        r_a = 8'hFF;
        tick();
        n_cmp++; if (w_cnt_1 !== 2'd3) begin n_err++; $display("FAIL sat_nowrap actual=%0d required=3", w_cnt_1); end
        r_a = 8'h00; r_cnt_clr = 1'b1;
        tick();
        n_cmp++; if (w_cnt_1 !== 2'd0) begin n_err++; $display("FAIL sat_clr_wins actual=%0d required=0", w_cnt_1); end
        n_cmp++; if (w_cnt_m !== 16'd0) begin n_err++; $display("FAIL clr_main actual=%0d required=0", w_cnt_m); end
        r_cnt_clr = 1'b0; r_a = 8'hFF;
        tick();
        n_cmp++; if (w_cnt_1 !== 2'd1) begin n_err++; $display("FAIL sat_restart actual=%0d required=1", w_cnt_1); end
        r_en = 1'b0; r_a = 8'h00;
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        r_en = 1'b1; r_a = 8'h00; r_mode_ld = 1'b1; r_mode_in = 2'd3;
        tick();
        r_mode_ld = 1'b0; r_a = 8'hFF; r_b = 8'hFF;
        tick();
        n_cmp++; if (w_q_m !== 8'hFF) begin n_err++; $display("FAIL b2b_q1 actual=%h required=FF", w_q_m); end
        tick();
        n_cmp++; if (w_q_m !== 8'h00) begin n_err++; $display("FAIL b2b_q2 actual=%h required=00", w_q_m); end
        r_a = 8'h3C; r_b = 8'h00;
        #2 r_res = 1'b1;
        #1;
        n_cmp++; if (w_q_m !== 8'hA5) begin n_err++; $display("FAIL midrst_q actual=%h required=A5", w_q_m); end
        n_cmp++; if (w_mode_m !== 2'd0) begin n_err++; $display("FAIL midrst_mode actual=%0d required=0", w_mode_m); end
        n_cmp++; if (w_cnt_m !== 16'd0) begin n_err++; $display("FAIL midrst_cnt actual=%0d required=0", w_cnt_m); end
        #1 r_res = 1'b0;
        tick();
        n_cmp++; if (w_q_m !== 8'h3C) begin n_err++; $display("FAIL post_rel_d actual=%h required=3C", w_q_m); end
        n_cmp++; if (w_mode_m !== 2'd0) begin n_err++; $display("FAIL post_rel_mode actual=%0d required=0", w_mode_m); end
        r_en = 1'b0; r_a = 8'h00;
    endtask

    initial begin
        test_reset();
        test_d_t();
        test_sr();
        test_jk();
        test_saturation();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
